audio_gain_ramp: RTL and testbench
==================================

Name: audio_gain_ramp

Overview:
- Stereo volume and soft-mute stage between the echo effect output and the S/PDIF encoder, in the clk domain.
- Scales each sample by a gain that ramps toward a target once per stereo frame, so volume changes and mute/unmute do not click.
- Multiply is a sequential shift-add, which costs no DSP blocks. At 10 MHz against 96k samples/s there is ample cycle budget.

Parameters:
- audio_width, 16, signed PCM sample width.
- gain_width, 8, gain fraction bits. Gain register is gain_width+1 bits; value 2^gain_width = unity (256).
- ramp_step, 1, gain change per completed stereo frame.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- i_valid, input, 1, upstream sample valid.
- i_ready, output, 1, block can accept a sample.
- i_is_left, input, 1, channel of the incoming sample.
- i_audio, input, audio_width, signed incoming sample.
- i_target_gain, input, gain_width+1, requested gain. Values above 2^gain_width clamp to 2^gain_width.
- i_mute, input, 1, when 1 the effective target is 0.
- o_valid, output, 1, output sample valid.
- o_ready, input, 1, downstream accepts.
- o_is_left, output, 1, channel of the output sample.
- o_audio, output, audio_width, scaled sample.
- o_muted, output, 1, i_mute=1 and current gain=0.

Behaviour:
- Reset values: i_ready=0 during reset, then 1 in IDLE. o_valid=0, o_audio=0, o_is_left=0, o_muted=0, current gain=0, state IDLE. Output fades in from silence after reset.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1. o_valid, o_audio and o_is_left hold stable until accepted.
- FSM states:
  - IDLE: i_ready=1. On i_valid, latch i_audio, i_is_left and current gain, then go to MUL.
  - MUL: i_ready=0. Runs exactly gain_width+1 cycles, one gain bit per cycle, LSB first, adding the sign-extended sample shifted left. Then go to OUT.
  - OUT: o_valid=1, i_ready=0. On o_ready, go to IDLE.
- Latency: input accepted in cycle 0, o_valid=1 in cycle gain_width+2. Minimum sample period is gain_width+3 cycles with o_ready tied high.
- Arithmetic:
  - Product is audio_width+gain_width+1 bits, signed.
  - o_audio = product arithmetic-shifted right by gain_width, i.e. truncation toward negative infinity.
  - Gain ≤ unity, so no overflow is possible and no saturation logic exists. Unity gain returns the input bit-exact, including -2^(audio_width-1).
- Gain ramp:
  - Effective target = 0 if i_mute, otherwise clamp(i_target_gain).
  - Updated only in the cycle an OUT handshake completes for a right-channel sample (o_is_left=0).
  - If current < target: current += min(ramp_step, target-current). If current > target: current -= min(ramp_step, current-target).
  - Never overshoots the target. L and R of a frame always use the same gain.
- Target and mute changes are sampled only at the update cycle. Changes mid-frame take effect at the next frame end.
- A left sample following a left sample (lost right) does not update gain; the block does no channel repair.
- Reset mid-MUL or mid-OUT: the in-flight sample is discarded, o_valid drops on the next edge, gain returns to 0.
- o_muted is registered and updates the cycle after the gain update.

Test Plan:
1. Reset, i_target_gain=256, i_mute=0, feed frames L=R=0x4000 with o_ready=1 -> frame 0 outputs 0x0000, frame 1 0x0040, frame 128 0x2000, frame ≥256 0x4000. Each output appears 10 cycles after accept.
2. Gain at 256, input -32768, then 0x7FFF -> outputs -32768 and 0x7FFF unchanged. Set target 128, input -1 after ramp completes -> output 0xFFFF (floor).
3. Gain at 256, assert i_mute -> gain drops 1 per frame, output 0x4000 after 255 frames reaches 0x0040, then 0. o_muted=1 one cycle after gain hits 0. Deassert -> ramps back up.
4. Hold o_ready=0 for 20 cycles in OUT -> o_valid stays 1, o_audio and o_is_left stable, i_ready=0. No gain update until the right sample handshakes.
5. i_target_gain=300 at gain 256 -> gain stays 256. Target 200 -> reaches 200 after exactly 56 frames, then holds.
6. Assert reset during MUL -> next cycle o_valid=0. After reset i_ready=1, and the next sample outputs 0 (gain 0).

Source files
------------

// File: rtl/audio_gain_ramp_if.sv
// Sample handshake bundle for the stereo gain/soft-mute stage.
// The master side feeds samples and control and accepts output; the slave side is the gain stage.
`timescale 1ns/1ps
interface audio_gain_ramp_if #(
   parameter int audio_width = 16,
   parameter int gain_width  = 8
);
   logic                          i_valid;
   logic                          i_ready;
   logic                          i_is_left;
   logic signed [audio_width-1:0] i_audio;
   logic        [gain_width:0]    i_target_gain;
   logic                          i_mute;
   logic                          o_valid;
   logic                          o_ready;
   logic                          o_is_left;
   logic signed [audio_width-1:0] o_audio;
   logic                          o_muted;

   modport master (
      output i_valid, i_is_left, i_audio, i_target_gain, i_mute, o_ready,
      input  i_ready, o_valid, o_is_left, o_audio, o_muted
   );

   modport slave (
      input  i_valid, i_is_left, i_audio, i_target_gain, i_mute, o_ready,
      output i_ready, o_valid, o_is_left, o_audio, o_muted
   );
endinterface

// File: rtl/audio_gain_ramp.sv
// Stereo volume / soft-mute stage: shift-add multiply by a gain that steps toward
// its target once per completed stereo frame, so level changes never click.
`timescale 1ns/1ps
module audio_gain_ramp #(
   parameter int audio_width = 16,
   parameter int gain_width  = 8,
   parameter int ramp_step   = 1
) (
   input  logic           clk,
   input  logic           reset,
   audio_gain_ramp_if.slave bus
);
   localparam int PW = audio_width + gain_width + 1;
   localparam int CW = $clog2(gain_width + 2);
   localparam logic [gain_width:0]     UNITY  = {1'b1, {gain_width{1'b0}}};
   localparam logic [gain_width:0]     STEP   = (gain_width+1)'(ramp_step);
   localparam logic [CW-1:0]           LAST   = CW'(gain_width);
   localparam logic signed [PW-1:0]    ZERO_P = '0;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

   state_t                         state_q, state_d;
   logic        [gain_width:0]     gain_q, gain_d;
   logic                           muted_q, muted_d;
   logic signed [audio_width-1:0]  out_audio_q, out_audio_d;
   logic                           out_left_q, out_left_d;
   logic        [CW-1:0]           cnt_q, cnt_d;
   logic signed [PW-1:0]           mcand_q, mcand_d;
   logic        [gain_width:0]     mplier_q, mplier_d;
   logic signed [PW-1:0]           acc_q, acc_d;
   logic                           samp_left_q, samp_left_d;

   function automatic logic [gain_width:0] eff_target(input logic [gain_width:0] tg,
                                                       input logic mute);
      if (mute)
         return '0;
      if (tg > UNITY)
         return UNITY;
      return tg;
   endfunction

   // Step toward the target without overshooting it.
   function automatic logic [gain_width:0] ramp_gain(input logic [gain_width:0] cur,
                                                      input logic [gain_width:0] tgt);
      logic [gain_width:0] diff;
      if (cur < tgt) begin
         diff = tgt - cur;
         return cur + ((diff > STEP) ? STEP : diff);
      end
      if (cur > tgt) begin
         diff = cur - tgt;
         return cur - ((diff > STEP) ? STEP : diff);
      end
      return cur;
   endfunction

   // Arithmetic shift right by gain_width: floor, never overflows since gain <= unity.
   function automatic logic signed [audio_width-1:0] scale_out(input logic signed [PW-1:0] p);
      return $signed(p[gain_width +: audio_width]);
   endfunction

   always_comb begin
      state_d       = state_q;
      gain_d        = gain_q;
      out_audio_d   = out_audio_q;
      out_left_d    = out_left_q;
      cnt_d         = cnt_q;
      mcand_d       = mcand_q;
      mplier_d      = mplier_q;
      acc_d         = acc_q;
      samp_left_d   = samp_left_q;
      muted_d       = bus.i_mute && (gain_q == '0);
      bus.i_ready   = 1'b0;
      bus.o_valid   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.i_ready = !reset;
            if (bus.i_valid) begin
               mcand_d     = {{(gain_width+1){bus.i_audio[audio_width-1]}}, bus.i_audio};
               mplier_d    = gain_q;
               acc_d       = '0;
               cnt_d       = '0;
               samp_left_d = bus.i_is_left;
               state_d     = S_MUL;
            end
         end
         S_MUL: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : ZERO_P);
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               out_audio_d = scale_out(acc_d);
               out_left_d  = samp_left_q;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            bus.o_valid = 1'b1;
            if (bus.o_ready) begin
               state_d = S_IDLE;
               // Gain only moves at the end of a frame so L and R share one gain.
               if (!out_left_q)
                  gain_d = ramp_gain(gain_q, eff_target(bus.i_target_gain, bus.i_mute));
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gain_q      <= '0;
         muted_q     <= 1'b0;
         out_audio_q <= '0;
         out_left_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         muted_q     <= muted_d;
         out_audio_q <= out_audio_d;
         out_left_q  <= out_left_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      samp_left_q <= samp_left_d;
   end

   assign bus.o_audio   = out_audio_q;
   assign bus.o_is_left = out_left_q;
   assign bus.o_muted   = muted_q;
endmodule

// File: tb/tb_audio_gain_ramp.sv
// Directed bench for audio_gain_ramp: fade-in, bit-exact unity, floor rounding,
// clamp, ramp length, soft mute, output back-pressure and mid-multiply reset.
`timescale 1ns/1ps
module tb_audio_gain_ramp;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_fail = 0;

   audio_gain_ramp_if #(.audio_width(16), .gain_width(8)) bus ();

   audio_gain_ramp #(.audio_width(16), .gain_width(8), .ramp_step(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic left, input logic [15:0] smp,
                       output logic [15:0] aud, output logic olft, output int lat);
      int w;
      w = 0;
      while (bus.i_ready !== 1'b1 && w < 50) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 50) chk("i_ready_timeout", 32'(w), 32'(0));
      bus.i_valid   = 1'b1;
      bus.i_is_left = left;
      bus.i_audio   = smp;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      lat = 1;
      while (bus.o_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      if (lat >= 50) chk("o_valid_timeout", 32'(lat), 32'(10));
      aud  = bus.o_audio;
      olft = bus.o_is_left;
      if (bus.o_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r,
                        output logic [15:0] al, output logic [15:0] ar,
                        output logic ll, output logic lr, output int lat);
      int lat_r;
      send(1'b1, l, al, ll, lat);
      send(1'b0, r, ar, lr, lat_r);
   endtask

   initial begin
      logic [15:0] al, ar;
      logic        ll, lr;
      int          lat;

      bus.i_valid       = 1'b0;
      bus.i_is_left     = 1'b0;
      bus.i_audio       = '0;
      bus.i_target_gain = 9'd256;
      bus.i_mute        = 1'b0;
      bus.o_ready       = 1'b1;
      reset             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_ready", bus.i_ready, 0);
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_o_audio", bus.o_audio, 0);
      chk("rst_o_is_left", bus.o_is_left, 0);
      chk("rst_o_muted", bus.o_muted, 0);
      reset = 1'b0;
      #1;
      chk("idle_i_ready", bus.i_ready, 1);

      // Fade-in from gain 0 toward unity
      for (int f = 0; f < 260; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 0) begin
            chk("f0_L", al, 16'h0000);
            chk("f0_R", ar, 16'h0000);
            chk("f0_latency", lat, 10);
            chk("f0_L_flag", ll, 1);
            chk("f0_R_flag", lr, 0);
         end
         if (f == 1)   begin chk("f1_L", al, 16'h0040); chk("f1_R", ar, 16'h0040); end
         if (f == 128) begin chk("f128_L", al, 16'h2000); chk("f128_R", ar, 16'h2000); end
         if (f == 256) begin chk("f256_L", al, 16'h4000); chk("f256_R", ar, 16'h4000); end
         if (f == 259) chk("f259_R", ar, 16'h4000);
      end

      // Unity is bit-exact at both extremes
      frame(16'h8000, 16'h7FFF, al, ar, ll, lr, lat);
      chk("unity_min", al, 16'h8000);
      chk("unity_max", ar, 16'h7FFF);

      // Ramp down to half gain, then floor rounding of negatives
      bus.i_target_gain = 9'd128;
      for (int f = 0; f < 128; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 127) chk("half_ramp_last", ar, 16'h2040);
      end
      frame(16'hFFFF, 16'hFFFD, al, ar, ll, lr, lat);
      chk("floor_m1", al, 16'hFFFF);
      chk("floor_m3", ar, 16'hFFFE);
      frame(16'h4000, 16'hC000, al, ar, ll, lr, lat);
      chk("half_pos", al, 16'h2000);
      chk("half_neg", ar, 16'hE000);

      // Target above unity clamps to unity
      bus.i_target_gain = 9'd300;
      for (int f = 0; f < 140; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 127) chk("clamp_ramp_255", ar, 16'h3FC0);
      end
      chk("clamp_hold", ar, 16'h4000);

      // Target 200 reached after exactly 56 frames
      bus.i_target_gain = 9'd200;
      for (int f = 0; f < 60; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 55) chk("t200_gain201", ar, 16'h3240);
         if (f == 56) chk("t200_gain200", ar, 16'h3200);
      end
      chk("t200_hold", ar, 16'h3200);

      // Back to unity, then soft mute
      bus.i_target_gain = 9'd256;
      for (int f = 0; f < 57; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 55) chk("up_gain255", ar, 16'h3FC0);
      end
      chk("up_unity", ar, 16'h4000);

      bus.i_mute = 1'b1;
      for (int f = 0; f < 256; f++) begin
         frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
         if (f == 0)   chk("mute_f0", ar, 16'h4000);
         if (f == 254) begin
            chk("mute_f254", ar, 16'h0080);
            chk("mute_f254_muted", bus.o_muted, 0);
         end
         if (f == 255) chk("mute_f255", ar, 16'h0040);
      end
      chk("muted_same_cycle", bus.o_muted, 0);
      @(posedge clk); #1;
      chk("muted_next_cycle", bus.o_muted, 1);
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("muted_silence_L", al, 16'h0000);
      chk("muted_silence_R", ar, 16'h0000);
      chk("muted_held", bus.o_muted, 1);

      bus.i_mute = 1'b0;
      @(posedge clk); #1;
      chk("unmute_flag", bus.o_muted, 0);
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("unmute_f0", ar, 16'h0000);
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("unmute_f1", ar, 16'h0040);

      // Back-pressure on both channels of one frame at gain 2
      bus.o_ready = 1'b0;
      send(1'b1, 16'h4000, al, ll, lat);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("stallL_o_valid", bus.o_valid, 1);
         chk("stallL_o_audio", bus.o_audio, 16'h0080);
         chk("stallL_o_is_left", bus.o_is_left, 1);
         chk("stallL_i_ready", bus.i_ready, 0);
      end
      bus.o_ready = 1'b1;
      @(posedge clk); #1;
      chk("stallL_released", bus.o_valid, 0);
      bus.o_ready = 1'b0;
      send(1'b0, 16'h4000, ar, lr, lat);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("stallR_o_valid", bus.o_valid, 1);
         chk("stallR_o_audio", bus.o_audio, 16'h0080);
         chk("stallR_o_is_left", bus.o_is_left, 0);
         chk("stallR_i_ready", bus.i_ready, 0);
      end
      bus.o_ready = 1'b1;
      @(posedge clk); #1;
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("after_stall_gain3_L", al, 16'h00C0);
      chk("after_stall_gain3_R", ar, 16'h00C0);

      // Reset in the middle of a multiply
      bus.i_valid   = 1'b1;
      bus.i_is_left = 1'b1;
      bus.i_audio   = 16'h4000;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midmul_rst_o_valid", bus.o_valid, 0);
      chk("midmul_rst_i_ready", bus.i_ready, 0);
      chk("midmul_rst_o_audio", bus.o_audio, 0);
      reset = 1'b0;
      #1;
      chk("midmul_post_i_ready", bus.i_ready, 1);
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("post_rst_L", al, 16'h0000);
      chk("post_rst_R", ar, 16'h0000);
      frame(16'h4000, 16'h4000, al, ar, ll, lr, lat);
      chk("post_rst_gain1", ar, 16'h0040);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
